// File: rtl/parc_test_mem_responder_pkg.sv
// Shared message widths, type codes, response layout and byte-lane helpers
// for the parc test memory responder.
package parc_test_mem_responder_pkg;

  localparam int TYPE_W = 1;
  localparam int ADDR_W = 32;
  localparam int LEN_W  = 2;
  localparam int DATA_W = 32;
  localparam int RESP_W = TYPE_W + LEN_W + DATA_W;

  typedef enum logic [0:0] {
    MEM_READ  = 1'b0,
    MEM_WRITE = 1'b1
  } mem_type_e;

  typedef struct packed {
    logic [TYPE_W-1:0] msg_type;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] data;
  } mem_resp_t;

  // A len of 0 means a full 4-byte word.
  function automatic logic [3:0] len_byte_mask(input logic [LEN_W-1:0] len);
    case (len)
      2'd1:    return 4'b0001;
      2'd2:    return 4'b0011;
      2'd3:    return 4'b0111;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] lanes_to_bits(input logic [3:0] lanes);
    logic [DATA_W-1:0] bits;
    for (int i = 0; i < 4; i++) bits[8*i +: 8] = {8{lanes[i]}};
    return bits;
  endfunction

endpackage

// File: rtl/parc_mem_resp_queue.sv
// In-order pointer-based response FIFO with full/empty flags; accepts an
// enqueue while full as long as a dequeue happens in the same cycle.
module parc_mem_resp_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 35
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enq_val,
  input  logic [WIDTH-1:0] enq_msg,
  output logic             deq_val,
  input  logic             deq_rdy,
  output logic [WIDTH-1:0] deq_msg,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] slots [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_enq;
  logic             do_deq;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_deq  = deq_rdy && !empty;
  assign do_enq  = enq_val && (!full || do_deq);
  assign deq_val = !empty;
  assign deq_msg = empty ? '0 : slots[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_enq) begin
        slots[wr_ptr] <= enq_msg;
        wr_ptr        <= bump(wr_ptr);
      end
      if (do_deq) rd_ptr <= bump(rd_ptr);
      if (do_enq != do_deq) count <= do_enq ? count + 1'b1 : count - 1'b1;
    end
  end

endmodule

// File: rtl/parc_test_mem_responder.sv
// Word-array test memory answering val/rdy requests in order after a fixed
// latency, with credit-based flow control into an output response queue.
module parc_test_mem_responder
  import parc_test_mem_responder_pkg::*;
#(
  parameter int MEM_WORDS   = 1024,
  parameter int LATENCY     = 1,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memreq_val,
  output logic              memreq_rdy,
  input  logic              memreq_msg_type,
  input  logic [ADDR_W-1:0] memreq_msg_addr,
  input  logic [LEN_W-1:0]  memreq_msg_len,
  input  logic [DATA_W-1:0] memreq_msg_data,
  output logic              memresp_val,
  input  logic              memresp_rdy,
  output logic              memresp_msg_type,
  output logic [LEN_W-1:0]  memresp_msg_len,
  output logic [DATA_W-1:0] memresp_msg_data
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

  logic [DATA_W-1:0] mem [MEM_WORDS];
  logic [IDX_W-1:0]  idx;
  logic [1:0]        off;
  logic [4:0]        shamt;
  logic [3:0]        byte_en;
  logic [DATA_W-1:0] wdata_lanes;
  logic [DATA_W-1:0] rdata;
  logic              is_write;
  logic              req_fire;
  logic              resp_fire;
  mem_resp_t         req_resp;
  mem_resp_t         enq_msg;
  mem_resp_t         head_msg;
  logic              enq_val;
  logic              q_full;
  logic              q_empty;
  logic              q_val;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  outstanding_next;
  logic              rdy_q;
  logic              unused_bits;

  assign idx       = memreq_msg_addr[IDX_W+1:2];
  assign off       = memreq_msg_addr[1:0];
  assign shamt     = {off, 3'b000};
  assign is_write  = (memreq_msg_type == MEM_WRITE);
  assign memreq_rdy = rdy_q;
  assign req_fire  = memreq_val && rdy_q && !reset;
  assign resp_fire = memresp_val && memresp_rdy;

  // Shifting the 4-bit lane mask by the offset drops lanes past byte 3.
  assign byte_en     = len_byte_mask(memreq_msg_len) << off;
  assign wdata_lanes = memreq_msg_data << shamt;
  assign rdata       = (mem[idx] >> shamt) & lanes_to_bits(len_byte_mask(memreq_msg_len));

  assign req_resp.msg_type = memreq_msg_type;
  assign req_resp.len      = memreq_msg_len;
  assign req_resp.data     = is_write ? '0 : rdata;

  always_ff @(posedge clk) begin
    if (req_fire && is_write) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
      end
    end
  end

  // The queue register itself supplies one cycle, so the pipe is LATENCY-1 deep.
  if (LATENCY == 1) begin : g_direct
    assign enq_val = req_fire;
    assign enq_msg = req_resp;
  end else begin : g_pipe
    logic      pipe_val [LATENCY-1];
    mem_resp_t pipe_msg [LATENCY-1];

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < LATENCY - 1; i++) pipe_val[i] <= 1'b0;
      end else begin
        pipe_val[0] <= req_fire;
        pipe_msg[0] <= req_resp;
        for (int i = 1; i < LATENCY - 1; i++) begin
          pipe_val[i] <= pipe_val[i-1];
          pipe_msg[i] <= pipe_msg[i-1];
        end
      end
    end

    assign enq_val = pipe_val[LATENCY-2];
    assign enq_msg = pipe_msg[LATENCY-2];
  end

  parc_mem_resp_queue #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (RESP_W)
  ) resp_queue (
    .clk     (clk),
    .reset   (reset),
    .enq_val (enq_val),
    .enq_msg (enq_msg),
    .deq_val (q_val),
    .deq_rdy (memresp_rdy),
    .deq_msg (head_msg),
    .full    (q_full),
    .empty   (q_empty)
  );

  assign memresp_val      = q_val;
  assign memresp_msg_type = head_msg.msg_type;
  assign memresp_msg_len  = head_msg.len;
  assign memresp_msg_data = head_msg.data;

  always_comb begin
    outstanding_next = outstanding;
    if (req_fire && !resp_fire)      outstanding_next = outstanding + 1'b1;
    else if (!req_fire && resp_fire) outstanding_next = outstanding - 1'b1;
  end

  // Ready is registered so memresp_rdy never reaches memreq_rdy combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding <= '0;
      rdy_q       <= 1'b1;
    end else begin
      outstanding <= outstanding_next;
      rdy_q       <= (outstanding_next < CNT_W'(QUEUE_DEPTH));
    end
  end

  assign unused_bits = ^{memreq_msg_addr[ADDR_W-1:IDX_W+2], q_full, q_empty};

endmodule

// File: tb/tb_parc_test_mem_responder.sv
// Self-checking bench: directed vector table, backpressure/reset sequences,
// LATENCY=3 throughput run, and randomized traffic against a byte-level model.
module tb_parc_test_mem_responder;
  import parc_test_mem_responder_pkg::*;

  localparam int LAT  = 1;
  localparam int QD   = 4;
  localparam int LAT3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        memreq_val, memreq_rdy, memreq_msg_type;
  logic [31:0] memreq_msg_addr, memreq_msg_data;
  logic [1:0]  memreq_msg_len;
  logic        memresp_val, memresp_rdy, memresp_msg_type;
  logic [1:0]  memresp_msg_len;
  logic [31:0] memresp_msg_data;

  logic        t_val, t_rdy, t_type, t_resp_val, t_resp_rdy, t_resp_type;
  logic [31:0] t_addr, t_data, t_resp_data;
  logic [1:0]  t_len, t_resp_len;

  parc_test_mem_responder #(.MEM_WORDS(1024), .LATENCY(LAT), .QUEUE_DEPTH(QD)) dut (
    .clk(clk), .reset(reset),
    .memreq_val(memreq_val), .memreq_rdy(memreq_rdy),
    .memreq_msg_type(memreq_msg_type), .memreq_msg_addr(memreq_msg_addr),
    .memreq_msg_len(memreq_msg_len), .memreq_msg_data(memreq_msg_data),
    .memresp_val(memresp_val), .memresp_rdy(memresp_rdy),
    .memresp_msg_type(memresp_msg_type), .memresp_msg_len(memresp_msg_len),
    .memresp_msg_data(memresp_msg_data)
  );

  parc_test_mem_responder #(.MEM_WORDS(1024), .LATENCY(LAT3), .QUEUE_DEPTH(QD)) dut3 (
    .clk(clk), .reset(reset),
    .memreq_val(t_val), .memreq_rdy(t_rdy),
    .memreq_msg_type(t_type), .memreq_msg_addr(t_addr),
    .memreq_msg_len(t_len), .memreq_msg_data(t_data),
    .memresp_val(t_resp_val), .memresp_rdy(t_resp_rdy),
    .memresp_msg_type(t_resp_type), .memresp_msg_len(t_resp_len),
    .memresp_msg_data(t_resp_data)
  );

  typedef struct {
    logic        typ;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
    logic [31:0] exp_data;
  } vec_t;

  typedef struct {
    logic        typ;
    logic [1:0]  len;
    logic [31:0] data;
    int          ready_cyc;
  } exp_resp_t;

  vec_t        vecs [16];
  exp_resp_t   exp_q [$];
  logic [7:0]  ref_mem [4096];
  int          cyc, n_vec, n_bad;
  logic        s_val, s_rdy, s_type, last_fire;
  logic [1:0]  s_len;
  logic [31:0] s_data;

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [31:0] addr, input logic [1:0] len);
    int word, off, nb;
    logic [31:0] d;
    word = int'(addr[11:2]);
    off  = int'(addr[1:0]);
    nb   = (len == 2'd0) ? 4 : int'(len);
    d    = 32'h0;
    for (int k = 0; k < nb; k++)
      if (off + k < 4) d = d | (32'(ref_mem[word*4 + off + k]) << (8*k));
    return d;
  endfunction

  task automatic ref_write(input logic [31:0] addr, input logic [1:0] len, input logic [31:0] data);
    int word, off, nb;
    word = int'(addr[11:2]);
    off  = int'(addr[1:0]);
    nb   = (len == 2'd0) ? 4 : int'(len);
    for (int k = 0; k < nb; k++)
      if (off + k < 4) ref_mem[word*4 + off + k] = data[8*k +: 8];
  endtask

  task automatic checkOutput();
    logic ev;
    ev = (exp_q.size() > 0) && (exp_q[0].ready_cyc <= cyc);
    compare("memreq_rdy", 32'(s_rdy), 32'(exp_q.size() < QD));
    compare("memresp_val", 32'(s_val), 32'(ev));
    if (ev) begin
      compare("memresp_type", 32'(s_type), 32'(exp_q[0].typ));
      compare("memresp_len", 32'(s_len), 32'(exp_q[0].len));
      compare("memresp_data", s_data, exp_q[0].data);
    end
  endtask

  // One clock cycle: drive, sample and check against the model, advance the model.
  task automatic applyStimulus(input logic rst, input logic val, input logic typ,
                               input logic [31:0] addr, input logic [1:0] len,
                               input logic [31:0] data, input logic rrdy);
    logic      ev, er;
    exp_resp_t r;
    reset = rst; memreq_val = val; memreq_msg_type = typ; memreq_msg_addr = addr;
    memreq_msg_len = len; memreq_msg_data = data; memresp_rdy = rrdy;
    #1;
    s_val = memresp_val; s_rdy = memreq_rdy; s_type = memresp_msg_type;
    s_len = memresp_msg_len; s_data = memresp_msg_data;
    checkOutput();
    ev = (exp_q.size() > 0) && (exp_q[0].ready_cyc <= cyc);
    er = (exp_q.size() < QD);
    last_fire = 1'b0;
    if (rst) exp_q.delete();
    else begin
      if (ev && rrdy) void'(exp_q.pop_front());
      if (val && er) begin
        r.typ = typ; r.len = len; r.ready_cyc = cyc + LAT;
        r.data = typ ? 32'h0 : ref_read(addr, len);
        if (typ) ref_write(addr, len, data);
        exp_q.push_back(r);
        last_fire = 1'b1;
      end
    end
    @(posedge clk); @(negedge clk);
    cyc++;
  endtask

  task automatic send(input logic typ, input logic [31:0] addr, input logic [1:0] len,
                      input logic [31:0] data, input logic rrdy);
    int tries;
    tries = 0;
    do begin
      applyStimulus(1'b0, 1'b1, typ, addr, len, data, rrdy);
      tries++;
    end while (!last_fire && tries < 20);
    if (!last_fire) begin
      n_vec++; n_bad++;
      $display("[TB] FAIL send_timeout: request to 0x%08h not accepted after %0d cycles", addr, tries);
    end
  endtask

  task automatic await_resp(output int lat, output logic [31:0] data);
    lat = 0; data = 32'hx;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 32'h0, 1'b1);
      lat++;
      if (s_val) begin data = s_data; break; end
    end
  endtask

  task automatic run_throughput();
    int acc, got, c, first_acc, first_resp, last_resp, stalls;
    for (int pass = 0; pass < 2; pass++) begin
      acc = 0; got = 0; c = 0; first_acc = -1; first_resp = -1; last_resp = -1; stalls = 0;
      t_resp_rdy = 1'b1;
      while (got < 20 && c < 200) begin
        t_val = (acc < 20); t_type = (pass == 0); t_addr = 32'(acc * 4); t_len = 2'd0;
        t_data = 32'h5A00_0000 + 32'(acc * 3);
        #1;
        if (t_resp_val) begin
          compare("tput_data", t_resp_data, (pass == 0) ? 32'h0 : 32'h5A00_0000 + 32'(got * 3));
          if (first_resp < 0) first_resp = c;
          last_resp = c;
          got++;
        end
        if (t_val) begin
          if (t_rdy) begin
            if (first_acc < 0) first_acc = c;
            acc++;
          end else stalls++;
        end
        @(posedge clk); @(negedge clk);
        c++;
      end
      t_val = 1'b0;
      compare("tput_count", 32'(got), 32'd20);
      compare("tput_first_latency", 32'(first_resp - first_acc), 32'(LAT3));
      compare("tput_spacing", 32'(last_resp - first_resp), 32'd19);
      compare("tput_stalls", 32'(stalls), 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          lat, acc, n;
    logic [31:0] got, held;
    logic [31:0] bp_addr [6];
    logic [1:0]  bp_len [6];

    vecs[0]  = '{1'b1, 32'h0000_0100, 2'd0, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[1]  = '{1'b0, 32'h0000_0100, 2'd0, 32'h0,         32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 32'h0000_0100, 2'd0, 32'h1122_3344, 32'h0000_0000};
    vecs[3]  = '{1'b1, 32'h0000_0102, 2'd1, 32'h7777_77AB, 32'h0000_0000};
    vecs[4]  = '{1'b0, 32'h0000_0100, 2'd0, 32'h0,         32'h11AB_3344};
    vecs[5]  = '{1'b0, 32'h0000_0103, 2'd2, 32'h0,         32'h0000_0011};
    vecs[6]  = '{1'b1, 32'h0000_0004, 2'd0, 32'h1234_5678, 32'h0000_0000};
    vecs[7]  = '{1'b1, 32'h0000_1000, 2'd0, 32'h0000_0055, 32'h0000_0000};
    vecs[8]  = '{1'b0, 32'h0000_0000, 2'd0, 32'h0,         32'h0000_0055};
    vecs[9]  = '{1'b1, 32'h0000_0003, 2'd2, 32'h9999_AAAA, 32'h0000_0000};
    vecs[10] = '{1'b0, 32'h0000_0000, 2'd0, 32'h0,         32'hAA00_0055};
    vecs[11] = '{1'b0, 32'h0000_0004, 2'd0, 32'h0,         32'h1234_5678};
    vecs[12] = '{1'b0, 32'h0000_0001, 2'd3, 32'h0,         32'h00AA_0000};
    vecs[13] = '{1'b0, 32'h0000_0102, 2'd2, 32'h0,         32'h0000_11AB};
    vecs[14] = '{1'b0, 32'h0000_2100, 2'd0, 32'h0,         32'h11AB_3344};
    vecs[15] = '{1'b0, 32'h0000_0101, 2'd1, 32'h0,         32'h0000_0033};

    bp_addr = '{32'h100, 32'h0, 32'h102, 32'h1, 32'h4, 32'h3};
    bp_len  = '{2'd0, 2'd0, 2'd2, 2'd3, 2'd0, 2'd0};

    n_vec = 0; n_bad = 0; cyc = 0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
    reset = 1'b1; memreq_val = 1'b0; memreq_msg_type = 1'b0; memreq_msg_addr = 32'h0;
    memreq_msg_len = 2'd0; memreq_msg_data = 32'h0; memresp_rdy = 1'b0;
    t_val = 1'b0; t_type = 1'b0; t_addr = 32'h0; t_len = 2'd0; t_data = 32'h0; t_resp_rdy = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    compare("reset_req_rdy", 32'(memreq_rdy), 32'd1);
    compare("reset_resp_val", 32'(memresp_val), 32'd0);
    compare("reset_resp_type", 32'(memresp_msg_type), 32'd0);
    compare("reset_resp_len", 32'(memresp_msg_len), 32'd0);
    compare("reset_resp_data", memresp_msg_data, 32'h0);
    compare("reset_resp_val_l3", 32'(t_resp_val), 32'd0);

    run_throughput();

    for (int i = 0; i < 16; i++) begin
      send(vecs[i].typ, vecs[i].addr, vecs[i].len, vecs[i].data, 1'b1);
      await_resp(lat, got);
      compare($sformatf("vec%0d_latency", i), 32'(lat), 32'(LAT));
      compare($sformatf("vec%0d_data", i), got, vecs[i].exp_data);
    end

    // Backpressure: only QUEUE_DEPTH reads get in and the head holds steady.
    acc = 0; held = 32'h0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, bp_addr[i], bp_len[i], 32'h0, 1'b0);
      if (last_fire) acc++;
      if (i == 1) held = s_data;
      if (i > 1) compare("bp_head_stable", s_data, held);
    end
    compare("bp_accepted", 32'(acc), 32'(QD));
    compare("bp_req_rdy_low", 32'(s_rdy), 32'd0);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 32'h0, 1'b1);
      if (s_val) n++;
      if (i == 1) compare("bp_req_rdy_back", 32'(s_rdy), 32'd1);
    end
    compare("bp_drained", 32'(n), 32'(QD));

    send(1'b1, 32'h300, 2'd0, 32'hCAFE_F00D, 1'b1);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) send(1'b0, 32'h100, 2'd0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 32'h0, 1'b0);
    reset = 1'b0;
    #1;
    compare("midrst_resp_val", 32'(memresp_val), 32'd0);
    compare("midrst_resp_data", memresp_msg_data, 32'h0);
    compare("midrst_req_rdy", 32'(memreq_rdy), 32'd1);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 32'h0, 1'b1);
      if (s_val) n++;
    end
    compare("midrst_stale_resps", 32'(n), 32'd0);
    send(1'b0, 32'h300, 2'd0, 32'h0, 1'b1);
    await_resp(lat, got);
    compare("midrst_mem_kept", got, 32'hCAFE_F00D);

    for (int i = 0; i < 16; i++)
      send(1'b1, 32'h200 + 32'(i * 4), 2'd0, $urandom, 1'b1);
    for (int i = 0; i < 400; i++)
      applyStimulus(1'b0, ($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
                    32'h200 + 32'($urandom_range(0, 63)) + (32'($urandom_range(0, 3)) << 12),
                    2'($urandom_range(0, 3)), $urandom, ($urandom_range(0, 9) < 6));
    repeat (12) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 32'h0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
